apb_rr_arbiter: RTL and testbench

Round-robin arbiter and APB4 sequencer that shares one APB master port between NUM_REQ on-chip requesters (AHB-to-APB bridge back end, DMA, debug port). Each requester issues a single-beat read/write over a valid/response handshake; the block grants one requester at a time, drives the full APB setup/access sequence, returns read data and error status, and aborts transfers whose slave never asserts PREADY. It lives entirely in the PCLK domain, downstream of any clock-domain crossing.

---
 rtl/apb_rr_arbiter_if.sv | 51 +++++
 rtl/apb_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of requester handshake and APB4 bus signals for apb_rr_arbiter.
// The master modport is the arbiter's view: it takes requests and slave
// responses, and drives completions and the APB request phase. The slave
// modport is the view of everything around it.
interface apb_rr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*SW-1:0]         req_strb;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic [IW-1:0]                 grant_id;
  logic                          busy;
  logic                          timeout_evt;

  // APB side
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [SW-1:0]         PSTRB;
  logic [2:0]            PPROT;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  PRDATA, PREADY, PSLVERR,
    output rsp_valid, rsp_rdata, rsp_err, grant_id, busy, timeout_evt,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output PRDATA, PREADY, PSLVERR,
    input  rsp_valid, rsp_rdata, rsp_err, grant_id, busy, timeout_evt,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter plus APB4 sequencer. It shares one APB master port
// between NUM_REQ single-beat requesters and aborts any ACCESS phase whose
// slave holds PREADY low for TIMEOUT cycles. TIMEOUT = 0 disables the abort.
module apb_rr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_rr_arbiter_if.master   bus
);
  localparam int          SW        = DATA_WIDTH / 8;
  localparam int          IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          OFFW      = $clog2(SW);
  localparam int unsigned NR        = NUM_REQ;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << OFFW) - 1);
  localparam logic [15:0] TO_LIM    = 16'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         last_q, last_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  tout_q, tout_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    eligible;
  logic                  found;
  logic [IW-1:0]         sel;

  // Next-state logic: round-robin pick in IDLE, then APB setup/access sequencing
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tout_d      = 1'b0;
    cnt_d       = cnt_q;

    // The requester being answered this cycle still shows req_valid, so it is
    // masked here to keep it from being granted a second time.
    eligible = bus.req_valid & ~rsp_valid_q;
    found    = 1'b0;
    sel      = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      if (!found && eligible[(32'(last_q) + k) % NR]) begin
        found = 1'b1;
        sel   = IW'((32'(last_q) + k) % NR);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d   = sel;
          pwrite_d  = bus.req_write[sel];
          paddr_d   = bus.req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_MASK;
          pwdata_d  = bus.req_write[sel] ? bus.req_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
          pstrb_d   = bus.req_write[sel] ? bus.req_strb[int'(sel)*SW +: SW] : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d            = bus.PSLVERR;
          last_d               = grant_q;
          state_d              = ST_IDLE;
        end else begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (TIMEOUT != 0 && cnt_d == TO_LIM) begin
            psel_d               = 1'b0;
            penable_d            = 1'b0;
            rsp_valid_d[grant_q] = 1'b1;
            rsp_rdata_d          = '0;
            rsp_err_d            = 1'b1;
            tout_d               = 1'b1;
            last_d               = grant_q;
            state_d              = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; last grant resets to NUM_REQ-1 so requester 0 wins first
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IW'(NUM_REQ - 1);
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tout_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tout_q      <= tout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.PPROT       = 3'b000;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.timeout_evt = tout_q;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: directed requests push expected APB
// phases and responses into queues; independent monitors pop and compare.
module tb_apb_rr_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } stim_t;

  typedef struct {
    int            id;
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tout;
    int            cyc;
  } exp_t;

  logic PCLK;
  logic PRESETn;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;

  exp_t  apb_q[$];
  exp_t  rsp_q[$];
  exp_t  cur_apb;
  stim_t pend[NR][$];

  int          s_waits = 0;
  logic [DW-1:0] s_rdata = '0;
  logic        s_err = 1'b0;

  apb_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_rr_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endfunction

  function automatic void push_exp(input int id, input logic w, input logic [AW-1:0] addr,
                                   input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                                   input logic [DW-1:0] rdata, input logic err, input logic tout,
                                   input int ecyc, input bit with_rsp);
    exp_t e;
    e.id = id; e.w = w; e.addr = addr; e.wdata = wdata; e.strb = strb;
    e.rdata = rdata; e.err = err; e.tout = tout; e.cyc = ecyc;
    apb_q.push_back(e);
    if (with_rsp) rsp_q.push_back(e);
  endfunction

  function automatic stim_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s);
    stim_t t;
    t.w = w; t.addr = a; t.wdata = d; t.strb = s;
    return t;
  endfunction

  task automatic load(input int i, input stim_t s);
    bus.req_valid[i]             = 1'b1;
    bus.req_write[i]             = s.w;
    bus.req_addr[i*AW +: AW]     = s.addr;
    bus.req_wdata[i*DW +: DW]    = s.wdata;
    bus.req_strb[i*SW +: SW]     = s.strb;
  endtask

  function automatic int pend_total();
    int n = 0;
    for (int i = 0; i < NR; i++) n += pend[i].size();
    return n;
  endfunction

  // Requester model: present each queued request, hold until its rsp_valid
  task automatic drive_all();
    int guard = 0;
    for (int i = 0; i < NR; i++) begin
      if (pend[i].size() > 0) load(i, pend[i][0]);
      else bus.req_valid[i] = 1'b0;
    end
    while (pend_total() != 0 && guard < 400) begin
      @(negedge PCLK);
      guard++;
      for (int i = 0; i < NR; i++) begin
        if (bus.rsp_valid[i] && pend[i].size() > 0) begin
          void'(pend[i].pop_front());
          if (pend[i].size() > 0) load(i, pend[i][0]);
          else bus.req_valid[i] = 1'b0;
        end
      end
    end
    chk("requests_done", 64'(pend_total()), 0);
  endtask

  task automatic chk_reset();
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_pstrb", bus.PSTRB, 0);
    chk("rst_pprot", bus.PPROT, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tout", bus.timeout_evt, 0);
    chk("rst_grant", bus.grant_id, 0);
  endtask

  // APB slave model: PREADY on the (s_waits+1)th ACCESS cycle, never if s_waits < 0
  initial begin
    int acnt;
    acnt = 0;
    bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (bus.PSEL && bus.PENABLE) begin
        if (s_waits >= 0 && acnt == s_waits) begin
          bus.PREADY = 1'b1; bus.PRDATA = s_rdata; bus.PSLVERR = s_err;
        end else begin
          bus.PREADY = 1'b0; bus.PRDATA = 32'hDEAD_0000 | 32'(acnt); bus.PSLVERR = 1'b1;
        end
        acnt++;
      end else begin
        acnt = 0;
        bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
      end
    end
  end

  // APB-side monitor: setup phase pops the expectation, access phase checks stability
  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESETn && bus.PSEL) begin
        if (!bus.PENABLE) begin
          chk("apb_expected", 64'(apb_q.size() != 0), 1);
          if (apb_q.size() != 0) begin
            cur_apb = apb_q.pop_front();
            chk("setup_grant", bus.grant_id, 64'(cur_apb.id));
            chk("setup_busy", bus.busy, 1);
            chk("setup_pprot", bus.PPROT, 0);
          end
        end
        chk("apb_paddr", bus.PADDR, cur_apb.addr);
        chk("apb_pwrite", bus.PWRITE, cur_apb.w);
        chk("apb_pwdata", bus.PWDATA, cur_apb.wdata);
        chk("apb_pstrb", bus.PSTRB, cur_apb.strb);
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && bus.rsp_valid != '0) begin
        chk("rsp_expected", 64'(rsp_q.size() != 0), 1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          chk("rsp_vec", bus.rsp_valid, 64'(1) << e.id);
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", bus.rsp_err, e.err);
          chk("rsp_tout", bus.timeout_evt, e.tout);
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("rsp_busy", bus.busy, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    int c;
    int guard;
    PRESETn = 1'b0;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb = '0;
    repeat (3) @(negedge PCLK);
    chk_reset();
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Single read, requester 0, unaligned address, garbage wdata/strb zeroed
    @(negedge PCLK);
    c = cyc;
    s_waits = 0; s_rdata = 32'hCAFE_BABE; s_err = 1'b0;
    push_exp(0, 1'b0, 32'h1000, '0, '0, 32'hCAFE_BABE, 1'b0, 1'b0, c + 3, 1);
    pend[0].push_back(mk(1'b0, 32'h1003, 32'h1234_5678, 4'hF));
    drive_all();

    // Both requesters back to back, writes, zero wait; last grant was 0 so 1 goes first
    @(negedge PCLK);
    c = cyc;
    s_waits = 0; s_rdata = 32'h5555_5555; s_err = 1'b0;
    push_exp(1, 1'b1, 32'h100, 32'h1111_1111, 4'hF, '0, 1'b0, 1'b0, c + 3, 1);
    push_exp(0, 1'b1, 32'h200, 32'hAAAA_0000, 4'hF, '0, 1'b0, 1'b0, c + 6, 1);
    push_exp(1, 1'b1, 32'h104, 32'h2222_2222, 4'hF, '0, 1'b0, 1'b0, c + 9, 1);
    push_exp(0, 1'b1, 32'h204, 32'hBBBB_0000, 4'hF, '0, 1'b0, 1'b0, c + 12, 1);
    pend[1].push_back(mk(1'b1, 32'h100, 32'h1111_1111, 4'hF));
    pend[1].push_back(mk(1'b1, 32'h104, 32'h2222_2222, 4'hF));
    pend[0].push_back(mk(1'b1, 32'h200, 32'hAAAA_0000, 4'hF));
    pend[0].push_back(mk(1'b1, 32'h204, 32'hBBBB_0000, 4'hF));
    drive_all();

    // Write with 3 wait states (one below the timeout) and PSLVERR at completion
    @(negedge PCLK);
    c = cyc;
    s_waits = 3; s_rdata = 32'hFFFF_FFFF; s_err = 1'b1;
    push_exp(0, 1'b1, 32'h2004, 32'hA5A5_5A5A, 4'b0110, '0, 1'b1, 1'b0, c + 6, 1);
    pend[0].push_back(mk(1'b1, 32'h2006, 32'hA5A5_5A5A, 4'b0110));
    drive_all();

    // Slave never ready: abort after TO access cycles
    @(negedge PCLK);
    c = cyc;
    s_waits = -1; s_rdata = 32'h7777_7777; s_err = 1'b0;
    push_exp(1, 1'b0, 32'h3000, '0, '0, '0, 1'b1, 1'b1, c + 2 + TO, 1);
    pend[1].push_back(mk(1'b0, 32'h3000, 32'h0, 4'h0));
    drive_all();

    // Normal read with one wait state right after the abort
    @(negedge PCLK);
    c = cyc;
    s_waits = 1; s_rdata = 32'h0BAD_F00D; s_err = 1'b0;
    push_exp(0, 1'b0, 32'h40, '0, '0, 32'h0BAD_F00D, 1'b0, 1'b0, c + 4, 1);
    pend[0].push_back(mk(1'b0, 32'h42, 32'h0, 4'h3));
    drive_all();

    // Reset during ACCESS: no response for the aborted transfer
    @(negedge PCLK);
    c = cyc;
    s_waits = -1;
    push_exp(1, 1'b0, 32'h700, '0, '0, '0, 1'b0, 1'b0, 0, 0);
    load(1, mk(1'b0, 32'h700, 32'h0, 4'h0));
    guard = 0;
    while (cyc < c + 3 && guard < 20) begin
      @(negedge PCLK);
      guard++;
    end
    chk("pre_reset_penable", bus.PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_psel", bus.PSEL, 0);
    chk("async_penable", bus.PENABLE, 0);
    chk("async_busy", bus.busy, 0);
    bus.req_valid = '0;
    @(negedge PCLK);
    chk_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);

    // After reset requester 0 has priority
    c = cyc;
    s_waits = 0; s_rdata = 32'h1357_9BDF; s_err = 1'b0;
    push_exp(0, 1'b0, 32'h500, '0, '0, 32'h1357_9BDF, 1'b0, 1'b0, c + 3, 1);
    push_exp(1, 1'b0, 32'h600, '0, '0, 32'h1357_9BDF, 1'b0, 1'b0, c + 6, 1);
    pend[0].push_back(mk(1'b0, 32'h500, 32'h0, 4'h0));
    pend[1].push_back(mk(1'b0, 32'h600, 32'h0, 4'h0));
    drive_all();

    repeat (5) @(negedge PCLK);
    chk("apb_q_drained", 64'(apb_q.size()), 0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
